// File: rtl/conjunto_reg_param_pkg.sv
// Shared constants and port-slicing helpers for the parametrised register file.
// Macros live beside the package so every file that imports it also sees them.
`ifndef CONJUNTO_REG_PARAM_MACROS
`define CONJUNTO_REG_PARAM_MACROS
`define CRP_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package conjunto_reg_param_pkg;

  localparam int unsigned REG_ZERO         = 0;
  localparam int unsigned N_WRITE_PORTS    = 2;
  localparam int unsigned BYPASS_DEFAULT   = 1;
  localparam int unsigned ZERO_REG_DEFAULT = 1;

endpackage

// File: rtl/conjunto_reg_param_rf_read_port.sv
// One combinational read port: stored value, optional write bypass with
// port-1 priority, and forced-zero for register 0 or while reset is held.
module rf_read_port
  import conjunto_reg_param_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned BYPASS   = BYPASS_DEFAULT,
  parameter int unsigned ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic                             flush,
  input  logic [AW-1:0]                    rd_addr,
  input  logic [WIDTH-1:0]                 stored_data,
  input  logic [N_WRITE_PORTS-1:0]         wr_valid,
  input  logic [N_WRITE_PORTS*AW-1:0]      wr_addr,
  input  logic [N_WRITE_PORTS*WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]                 rd_data_c
);

  localparam bit BYP = (BYPASS != 0);
  localparam bit ZR  = (ZERO_REG != 0);

  logic [N_WRITE_PORTS-1:0] hit;
  logic                     force_zero;

  always_comb begin : addr_compare
    hit = '0;
    for (int k = 0; k < N_WRITE_PORTS; k++) begin
      hit[k] = BYP && wr_valid[k] && (`CRP_SLICE(wr_addr, k, AW) == rd_addr);
    end
  end

  assign force_zero = flush || (ZR && (rd_addr == AW'(REG_ZERO)));

  // Later write ports override earlier ones, matching storage priority.
  always_comb begin : bypass_mux
    rd_data_c = stored_data;
    for (int k = 0; k < N_WRITE_PORTS; k++) begin
      if (hit[k]) rd_data_c = `CRP_SLICE(wr_data, k, WIDTH);
    end
    if (force_zero) rd_data_c = '0;
  end

endmodule

// File: rtl/conjunto_reg_param.sv
// Parametrised register file with two prioritised write ports, NR read ports,
// optional write-to-read bypass and a per-register busy scoreboard.
module conjunto_reg_param
  import conjunto_reg_param_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NR       = 2,
  parameter int unsigned BYPASS   = BYPASS_DEFAULT,
  parameter int unsigned ZERO_REG = ZERO_REG_DEFAULT,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_WRITE_PORTS-1:0]       write_enable,
  input  logic [N_WRITE_PORTS*AW-1:0]    write_addr,
  input  logic [N_WRITE_PORTS*WIDTH-1:0] write_data,
  input  logic [NR*AW-1:0]               addr,
  output logic [NR*WIDTH-1:0]            data,
  output logic [NR-1:0]                  busy,
  input  logic                           busy_set,
  input  logic [AW-1:0]                  busy_set_addr
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [WIDTH-1:0]         regs_q [DEPTH];
  logic [WIDTH-1:0]         regs_d [DEPTH];
  logic [DEPTH-1:0]         busy_q;
  logic [DEPTH-1:0]         busy_d;
  logic [AW-1:0]            wa     [N_WRITE_PORTS];
  logic [WIDTH-1:0]         wd     [N_WRITE_PORTS];
  logic [N_WRITE_PORTS-1:0] wr_ok;

  // Unpack write ports; a write to register 0 is dropped when it is hardwired.
  always_comb begin : write_unpack
    for (int k = 0; k < N_WRITE_PORTS; k++) begin
      wa[k]    = `CRP_SLICE(write_addr, k, AW);
      wd[k]    = `CRP_SLICE(write_data, k, WIDTH);
      wr_ok[k] = write_enable[k] && !(ZR && (wa[k] == AW'(REG_ZERO)));
    end
  end

  // Port 1 is applied last so it wins on an address clash; a new busy_set
  // overrides the clear from a writeback to the same register.
  always_comb begin : next_state
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < N_WRITE_PORTS; k++) begin
      if (wr_ok[k]) begin
        regs_d[wa[k]] = wd[k];
        busy_d[wa[k]] = 1'b0;
      end
    end
    if (busy_set && !(ZR && (busy_set_addr == AW'(REG_ZERO)))) begin
      busy_d[busy_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    assign rd_addr = `CRP_SLICE(addr, i, AW);

    rf_read_port #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .flush       (reset),
      .rd_addr     (rd_addr),
      .stored_data (regs_q[rd_addr]),
      .wr_valid    (wr_ok),
      .wr_addr     (write_addr),
      .wr_data     (write_data),
      .rd_data_c   (rd_data)
    );

    assign `CRP_SLICE(data, i, WIDTH) = rd_data;
    // Scoreboard is read from the registered bits only; no same-cycle forwarding.
    assign busy[i] = busy_q[rd_addr];
  end

endmodule

// File: tb/tb_conjunto_reg_param.sv
// Randomised and directed bench for conjunto_reg_param: default instance plus a
// wide/no-bypass/no-zero-reg instance, both checked against array models.
module tb_conjunto_reg_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Default instance: WIDTH=32 DEPTH=32 NR=2 BYPASS=1 ZERO_REG=1
  logic [1:0]  m_we = '0;
  logic [9:0]  m_wa = '0;
  logic [63:0] m_wd = '0;
  logic [9:0]  m_addr = '0;
  logic [63:0] m_data;
  logic [1:0]  m_busy;
  logic        m_bs = 1'b0;
  logic [4:0]  m_bsa = '0;

  // Alternate instance: WIDTH=64 DEPTH=16 NR=3 BYPASS=0 ZERO_REG=0
  logic [1:0]   a_we = '0;
  logic [7:0]   a_wa = '0;
  logic [127:0] a_wd = '0;
  logic [11:0]  a_addr = '0;
  logic [191:0] a_data;
  logic [2:0]   a_busy;
  logic         a_bs = 1'b0;
  logic [3:0]   a_bsa = '0;

  conjunto_reg_param u_dut (
    .clk(clk), .reset(reset), .write_enable(m_we), .write_addr(m_wa),
    .write_data(m_wd), .addr(m_addr), .data(m_data), .busy(m_busy),
    .busy_set(m_bs), .busy_set_addr(m_bsa)
  );

  conjunto_reg_param #(.WIDTH(64), .DEPTH(16), .NR(3), .BYPASS(0), .ZERO_REG(0)) u_alt (
    .clk(clk), .reset(reset), .write_enable(a_we), .write_addr(a_wa),
    .write_data(a_wd), .addr(a_addr), .data(a_data), .busy(a_busy),
    .busy_set(a_bs), .busy_set_addr(a_bsa)
  );

  // Reference state
  logic [31:0] mm [32];
  bit          mb [32];
  logic [63:0] am [16];
  bit          ab [16];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Value a read port must return this cycle, from the architectural rules.
  function automatic logic [63:0] model_read(input int a, input bit zr, input bit byp,
                                              input logic [1:0] we, input int wa0, input int wa1,
                                              input logic [63:0] wd0, input logic [63:0] wd1,
                                              input logic [63:0] stored);
    if (zr && a == 0) return 64'h0;
    if (byp) begin
      if (we[1] && wa1 == a) return wd1;
      if (we[0] && wa0 == a) return wd0;
    end
    return stored;
  endfunction

  task automatic clear_models();
    for (int r = 0; r < 32; r++) begin mm[r] = '0; mb[r] = 1'b0; end
    for (int r = 0; r < 16; r++) begin am[r] = '0; ab[r] = 1'b0; end
  endtask

  task automatic commit_models();
    int a;
    for (int k = 0; k < 2; k++) begin
      if (m_we[k]) begin
        a = int'(m_wa[k*5 +: 5]);
        if (a != 0) begin mm[a] = m_wd[k*32 +: 32]; mb[a] = 1'b0; end
      end
      if (a_we[k]) begin
        a = int'(a_wa[k*4 +: 4]);
        am[a] = a_wd[k*64 +: 64];
        ab[a] = 1'b0;
      end
    end
    if (m_bs && m_bsa != 5'd0) mb[m_bsa] = 1'b1;
    if (a_bs) ab[a_bsa] = 1'b1;
  endtask

  task automatic check_main(input string tag);
    int a;
    logic [63:0] exp;
    for (int i = 0; i < 2; i++) begin
      a = int'(m_addr[i*5 +: 5]);
      exp = reset ? 64'h0 : model_read(a, 1'b1, 1'b1, m_we, int'(m_wa[4:0]), int'(m_wa[9:5]),
                                       64'(m_wd[31:0]), 64'(m_wd[63:32]), 64'(mm[a]));
      check_eq($sformatf("%s_m_data%0d", tag, i), 64'(m_data[i*32 +: 32]), exp);
      check_eq($sformatf("%s_m_busy%0d", tag, i), 64'(m_busy[i]), reset ? 64'h0 : 64'(mb[a]));
    end
  endtask

  task automatic check_alt(input string tag);
    int a;
    logic [63:0] exp;
    for (int i = 0; i < 3; i++) begin
      a = int'(a_addr[i*4 +: 4]);
      exp = reset ? 64'h0 : model_read(a, 1'b0, 1'b0, a_we, int'(a_wa[3:0]), int'(a_wa[7:4]),
                                       a_wd[63:0], a_wd[127:64], am[a]);
      check_eq($sformatf("%s_a_data%0d", tag, i), a_data[i*64 +: 64], exp);
      check_eq($sformatf("%s_a_busy%0d", tag, i), 64'(a_busy[i]), reset ? 64'h0 : 64'(ab[a]));
    end
  endtask

  // Advance one edge; models follow the DUT state update (or reset).
  task automatic tick();
    @(posedge clk);
    if (reset) clear_models();
    else commit_models();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_we = '0; m_bs = 1'b0; a_we = '0; a_bs = 1'b0;
  endtask

  function automatic int rnd_addr(input int depth);
    if ($urandom_range(0, 1) != 0) return int'($urandom_range(0, 3));
    return int'($urandom_range(0, depth - 1));
  endfunction

  task automatic randomize_inputs();
    m_we   = 2'($urandom);
    m_wa   = {5'(rnd_addr(32)), 5'(rnd_addr(32))};
    m_wd   = {$urandom, $urandom};
    m_addr = {5'(rnd_addr(32)), 5'(rnd_addr(32))};
    m_bs   = 1'($urandom);
    m_bsa  = 5'(rnd_addr(32));
    a_we   = 2'($urandom);
    a_wa   = {4'(rnd_addr(16)), 4'(rnd_addr(16))};
    a_wd   = {$urandom, $urandom, $urandom, $urandom};
    a_addr = {4'(rnd_addr(16)), 4'(rnd_addr(16)), 4'(rnd_addr(16))};
    a_bs   = 1'($urandom);
    a_bsa  = 4'(rnd_addr(16));
  endtask

  initial begin
    clear_models();

    // Reset held for two edges with busy traffic on the inputs
    @(negedge clk);
    randomize_inputs();
    m_we = 2'b11; m_bs = 1'b1;
    tick();
    tick();
    #1 check_main("rst_held");
    check_alt("rst_held");
    check_eq("rst_data_zero", m_data, 64'h0);
    #3 reset = 1'b0;
    idle_inputs();

    // Write r5 then async reset between edges wipes it immediately
    @(negedge clk);
    m_we = 2'b01; m_wa = {5'd0, 5'd5}; m_wd = {32'h0, 32'h5041544F}; m_addr = {5'd5, 5'd5};
    tick();
    idle_inputs();
    #1 check_main("r5_written");
    check_eq("r5_value", 64'(m_data[31:0]), 64'h5041544F);
    #1 reset = 1'b1;
    clear_models();
    #1 check_main("r5_mid_reset");
    check_eq("r5_reset_zero", 64'(m_data[31:0]), 64'h0);
    #1 reset = 1'b0;
    #1 check_main("r5_after_reset");

    // Register 0 ignores writes and busy_set
    @(negedge clk);
    m_we = 2'b01; m_wa = {5'd0, 5'd0}; m_wd = {32'h0, 32'h5041544F}; m_addr = {5'd0, 5'd0};
    m_bs = 1'b1; m_bsa = 5'd0;
    #1 check_main("x0_pre");
    tick();
    idle_inputs();
    #1 check_main("x0_post");
    check_eq("x0_data", 64'(m_data[63:32]), 64'h0);
    check_eq("x0_busy", 64'(m_busy), 64'h0);

    // Dual write conflict: port 1 wins, visible by bypass and in storage
    @(negedge clk);
    m_we = 2'b11; m_wa = {5'd3, 5'd3}; m_wd = {32'h22222222, 32'h11111111}; m_addr = {5'd3, 5'd3};
    #1 check_main("conflict_pre");
    tick();
    idle_inputs();
    #1 check_main("conflict_post");
    check_eq("conflict_r3", 64'(m_data[31:0]), 64'h22222222);

    // Bypass on the default instance
    @(negedge clk);
    m_we = 2'b01; m_wa = {5'd0, 5'd1}; m_wd = {32'h0, 32'h5041544F}; m_addr = {5'd1, 5'd1};
    #1 check_eq("bypass_r1", 64'(m_data[31:0]), 64'h5041544F);
    check_main("bypass_pre");
    tick();
    idle_inputs();

    // Scoreboard set, clear, and simultaneous set+clear
    @(negedge clk);
    m_bs = 1'b1; m_bsa = 5'd7; m_addr = {5'd0, 5'd7};
    #1 check_eq("sb_before_set", 64'(m_busy[0]), 64'h0);
    tick();
    idle_inputs();
    #1 check_eq("sb_set", 64'(m_busy[0]), 64'h1);
    @(negedge clk);
    m_we = 2'b10; m_wa = {5'd7, 5'd0}; m_wd = {32'hCAFE0007, 32'h0};
    #1 check_eq("sb_not_bypassed", 64'(m_busy[0]), 64'h1);
    tick();
    idle_inputs();
    #1 check_eq("sb_cleared", 64'(m_busy[0]), 64'h0);
    @(negedge clk);
    m_we = 2'b01; m_wa = {5'd0, 5'd7}; m_wd = {32'h0, 32'h0000ABCD}; m_bs = 1'b1; m_bsa = 5'd7;
    tick();
    idle_inputs();
    #1 check_eq("sb_set_wins", 64'(m_busy[0]), 64'h1);
    check_eq("sb_data_updated", 64'(m_data[31:0]), 64'h0000ABCD);
    check_main("sb_model");

    // Alternate instance: no bypass, wide data, three aliased ports, r0 ordinary
    @(negedge clk);
    a_we = 2'b01; a_wa = {4'd0, 4'd15}; a_wd = {64'h0, 64'hDEADBEEF_5041544F};
    a_addr = {4'd15, 4'd15, 4'd15};
    #1 check_eq("nobyp_old", a_data[63:0], 64'h0);
    check_alt("nobyp_pre");
    tick();
    idle_inputs();
    #1 for (int i = 0; i < 3; i++)
      check_eq($sformatf("wide_r15_p%0d", i), a_data[i*64 +: 64], 64'hDEADBEEF_5041544F);
    @(negedge clk);
    a_we = 2'b10; a_wa = {4'd0, 4'd0}; a_wd = {64'h0123456789ABCDEF, 64'h0};
    a_addr = {4'd0, 4'd15, 4'd0}; a_bs = 1'b1; a_bsa = 4'd0;
    tick();
    idle_inputs();
    #1 check_eq("alt_r0_data", a_data[191:128], 64'h0123456789ABCDEF);
    check_eq("alt_r0_busy", 64'(a_busy[2]), 64'h1);
    check_alt("alt_r0_model");

    // Randomised traffic with occasional async reset pulses
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      randomize_inputs();
      if ($urandom_range(0, 24) == 0) begin
        #1 reset = 1'b1;
        clear_models();
        #1 check_main("rnd_rst");
        check_alt("rnd_rst");
        @(posedge clk);
        clear_models();
        #2 reset = 1'b0;
      end else begin
        #1 check_main("rnd");
        check_alt("rnd");
        @(posedge clk);
        commit_models();
      end
    end

    @(negedge clk);
    idle_inputs();
    #1 check_main("final");
    check_alt("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
